ex_muldiv_sequencer: RTL and testbench
======================================

// Module: ex_muldiv_sequencer
// PURPOSE
//  Multi-cycle RV32M multiply/divide unit and its sequencer, beside the execute-stage ALU.
//  Accepts one M-extension op from execute and runs an iterative shift-add multiply or restoring divide.
//  Stalls the pipeline until the op completes, then presents the result to execute for writeback muxing.
//  Resolves divide-by-zero and signed-overflow in the fast path.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN; counter width = $clog2(XLEN)+1
// PORTS
//  i_clk     in   1     clock, rising edge
//  i_rst     in   1     synchronous active-high reset
//  i_valid   in   1     execute stage holds an M-extension op; held high while o_stall=1
//  i_funct3  in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  i_op_a    in   XLEN  rs1 data (forwarded)
//  i_op_b    in   XLEN  rs2 data (forwarded)
//  i_flush   in   1     branch/jump redirect; kills the in-flight op
//  o_stall   out  1     combinational: i_valid & ~o_valid & ~i_flush; freezes IF/ID/EX
//  o_busy    out  1     state==RUN
//  o_valid   out  1     result valid; exactly one cycle per completed op
//  o_result  out  XLEN  result; holds its last value when o_valid=0
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, o_valid=0, o_busy=0, o_result=0, all internal regs=0.
//  Reset has priority over flush; flush has priority over every other transition.
//  FSM: IDLE, RUN, DONE.
//   IDLE -> RUN   on i_valid & ~i_flush, cycle T.
//     At T, latch funct3, magnitude operands, and result-sign flag; clear accumulator; counter=XLEN.
//   IDLE -> DONE  at T instead, for special cases:
//     DIV/DIVU with b=0: quotient=all ones; REM/REMU with b=0: result=a.
//     DIV with a=0x80000000 and b=-1: result=0x80000000; REM with the same operands: result=0.
//   RUN: one bit per cycle, counter decrements, exactly XLEN cycles (T+1 .. T+XLEN).
//   RUN -> DONE   when counter reaches 1 at the edge; final sign correction applied on that edge.
//   DONE -> IDLE  unconditionally after one cycle; o_valid=1 only in DONE.
//     i_valid high in DONE is the same instruction and is never re-accepted.
//  Latency: normal op o_valid at T+XLEN+1 (33 for XLEN=32); special case o_valid at T+1.
//  o_stall high from T through the cycle before DONE; low in DONE so the pipeline advances that edge.
//  Back-to-back: a new op can be accepted the cycle after DONE (IDLE).
//  Multiply: 2*XLEN-bit product of magnitudes.
//   MUL: low XLEN bits. MULH/MULHSU/MULHU: high XLEN bits.
//   Signedness: MULH a,b signed; MULHSU a signed, b unsigned; MULHU both unsigned.
//   Negate the full 2*XLEN product when the result sign is negative, before selecting bits.
//  Divide: restoring on magnitudes.
//   Quotient sign = sa^sb (signed ops). Remainder sign = sign of dividend. Unsigned ops take no sign fixup.
//  i_flush in RUN or DONE: IDLE next cycle, no o_valid, o_result unchanged.
//   i_flush in IDLE: op not accepted.
//  i_funct3 and operand changes after T are ignored; latched copies are used.
// TESTING
//  MUL 7 * 0xFFFFFFFD -> o_result=0xFFFFFFEB, o_valid exactly 33 cycles after accept, o_stall high 33 cycles.
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  Special cases:
//   DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; each with o_valid at T+1.
//   DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
//  Flush/restart: i_flush at cycle T+10 -> no o_valid.
//   Then DIVU 9/3 accepted next IDLE cycle -> 3 at its T+33.
//  Reset mid-RUN at T+5 -> next cycle IDLE with o_valid=0, o_busy=0, o_result=0.
//   Back-to-back MUL then DIV -> two o_valid pulses exactly 34 cycles apart.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Execute-stage <-> multiply/divide unit handshake bundle.
// i_valid is held by execute until o_valid; o_valid pulses for exactly one cycle per op.
interface ex_muldiv_if #(parameter int XLEN = 32);
   logic            i_valid;
   logic [2:0]      i_funct3;
   logic [XLEN-1:0] i_op_a;
   logic [XLEN-1:0] i_op_b;
   logic            i_flush;
   logic            o_stall;
   logic            o_busy;
   logic            o_valid;
   logic [XLEN-1:0] o_result;
   logic [1:0]      dbg_state;

   modport master (
      output i_valid, i_funct3, i_op_a, i_op_b, i_flush,
      input  o_stall, o_busy, o_valid, o_result, dbg_state
   );

   modport slave (
      input  i_valid, i_funct3, i_op_a, i_op_b, i_flush,
      output o_stall, o_busy, o_valid, o_result, dbg_state
   );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// Iterative RV32M multiply (shift-add) / divide (restoring) unit with its IDLE/RUN/DONE sequencer.
// Operates on magnitudes; sign is restored on the last iteration edge.
module ex_muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   ex_muldiv_if.slave  bus
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     count;
   logic [2:0]        funct3_q;
   logic [XLEN-1:0]   opnd_q;
   logic [2*XLEN-1:0] work_q;
   logic              neg_q;
   logic [XLEN-1:0]   result_q;

   // Operand decode, valid only in the accept cycle
   logic              accept;
   logic              a_signed, b_signed, sa, sb, neg_in;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              b_zero, div_ovf, special;
   logic [XLEN-1:0]   special_result;

   always_comb begin
      accept   = (state == IDLE) & bus.i_valid & ~bus.i_flush;
      a_signed = (bus.i_funct3 == 3'b001) | (bus.i_funct3 == 3'b010) |
                 (bus.i_funct3 == 3'b100) | (bus.i_funct3 == 3'b110);
      b_signed = (bus.i_funct3 == 3'b001) | (bus.i_funct3 == 3'b100) |
                 (bus.i_funct3 == 3'b110);
      sa       = a_signed & bus.i_op_a[XLEN-1];
      sb       = b_signed & bus.i_op_b[XLEN-1];
      mag_a    = sa ? -bus.i_op_a : bus.i_op_a;
      mag_b    = sb ? -bus.i_op_b : bus.i_op_b;
      // Remainder takes the dividend's sign; everything else the product of signs
      neg_in   = (bus.i_funct3[2] & bus.i_funct3[1]) ? sa : (sa ^ sb);
      b_zero   = (bus.i_op_b == '0);
      div_ovf  = ~bus.i_funct3[0] & (bus.i_op_a == MIN_NEG) & (bus.i_op_b == '1);
      special  = bus.i_funct3[2] & (b_zero | div_ovf);
      if (b_zero)
         special_result = bus.i_funct3[1] ? bus.i_op_a : '1;
      else
         special_result = bus.i_funct3[1] ? '0 : MIN_NEG;
   end

   // One iteration: work_q holds {acc, multiplier} for MUL, {remainder, quotient} for DIV
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_partial;
   logic [XLEN-1:0]   div_diff;
   logic [2*XLEN-1:0] step;
   logic [2*XLEN-1:0] mul_full;
   logic [XLEN-1:0]   div_val;
   logic [XLEN-1:0]   final_result;

   always_comb begin
      mul_sum     = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opnd_q} : '0);
      div_partial = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
      div_diff    = div_partial[XLEN-1:0] - opnd_q;
      if (funct3_q[2]) begin
         if (div_partial >= {1'b0, opnd_q})
            step = {div_diff, work_q[XLEN-2:0], 1'b1};
         else
            step = {div_partial[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
      end else begin
         step = {mul_sum, work_q[XLEN-1:1]};
      end
      mul_full = neg_q ? -step : step;
      div_val  = funct3_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
      if (funct3_q[2])
         final_result = neg_q ? -div_val : div_val;
      else if (funct3_q[1:0] == 2'b00)
         final_result = mul_full[XLEN-1:0];
      else
         final_result = mul_full[2*XLEN-1:XLEN];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = special ? DONE : RUN;
         RUN: begin
            if (bus.i_flush)            state_nxt = IDLE;
            else if (count == CW'(1))   state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count    <= '0;
         funct3_q <= '0;
         opnd_q   <= '0;
         work_q   <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else if (accept) begin
         funct3_q <= bus.i_funct3;
         neg_q    <= neg_in;
         if (bus.i_funct3[2]) begin
            opnd_q <= mag_b;
            work_q <= {{XLEN{1'b0}}, mag_a};
         end else begin
            opnd_q <= mag_a;
            work_q <= {{XLEN{1'b0}}, mag_b};
         end
         if (special) begin
            count    <= '0;
            result_q <= special_result;
         end else begin
            count    <= CW'(XLEN);
         end
      end else if (state == RUN) begin
         if (bus.i_flush) begin
            count <= '0;
         end else begin
            work_q <= step;
            count  <= count - CW'(1);
            if (count == CW'(1)) result_q <= final_result;
         end
      end
   end

   assign bus.o_valid   = (state == DONE);
   assign bus.o_busy    = (state == RUN);
   assign bus.o_stall   = bus.i_valid & ~bus.o_valid & ~bus.i_flush;
   assign bus.o_result  = result_q;
   assign bus.dbg_state = state;
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Randomised scoreboard bench for ex_muldiv_sequencer against an arithmetic reference model.
module tb_ex_muldiv_sequencer;
   localparam int XLEN = 32;
   localparam logic [31:0] MIN_NEG = 32'h8000_0000;
   localparam logic [31:0] ONES    = 32'hFFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic [XLEN-1:0] exp_q[$];
   int              pulse_q[$];
   logic [XLEN-1:0] last_exp = '0;

   ex_muldiv_if #(.XLEN(XLEN)) bus ();

   ex_muldiv_sequencer #(.XLEN(XLEN)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   // Clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: RV32M semantics via 64-bit arithmetic on extended operands
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] xa_s, xb_s, xa_u, xb_u, p;
      int          ia, ib;
      logic [31:0] r;
      xa_s = {{32{a[31]}}, a};
      xb_s = {{32{b[31]}}, b};
      xa_u = {32'b0, a};
      xb_u = {32'b0, b};
      ia   = a;
      ib   = b;
      r    = '0;
      case (f)
         3'd0: begin p = xa_u * xb_u; r = p[31:0];  end
         3'd1: begin p = xa_s * xb_s; r = p[63:32]; end
         3'd2: begin p = xa_s * xb_u; r = p[63:32]; end
         3'd3: begin p = xa_u * xb_u; r = p[63:32]; end
         3'd4: r = (b == 0) ? ONES : ((a == MIN_NEG && b == ONES) ? MIN_NEG : 32'(ia / ib));
         3'd5: r = (b == 0) ? ONES : a / b;
         3'd6: r = (b == 0) ? a : ((a == MIN_NEG && b == ONES) ? 32'd0 : 32'(ia % ib));
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Monitor: pops one expectation per o_valid pulse
   always @(negedge clk) begin
      if (!rst && bus.o_valid) begin
         pulse_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got result %h with no op outstanding (cycle %0d)",
                     bus.o_result, cyc);
         end else begin
            last_exp = exp_q.pop_front();
            check("result", bus.o_result, last_exp);
         end
      end
   end

   task automatic idle_inputs();
      bus.i_valid  = 1'b0;
      bus.i_flush  = 1'b0;
      bus.i_funct3 = '0;
      bus.i_op_a   = '0;
      bus.i_op_b   = '0;
   endtask

   // Driver: starts and ends #1 after a rising edge; holds i_valid until o_valid
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int c = 0;
      int stalls = 0;
      bit seen = 0;
      bit special;
      int exp_lat;
      special = f[2] && (b == 0 || (!f[0] && a == MIN_NEG && b == ONES));
      exp_lat = special ? 1 : XLEN + 1;
      bus.i_valid  = 1'b1;
      bus.i_funct3 = f;
      bus.i_op_a   = a;
      bus.i_op_b   = b;
      exp_q.push_back(model(f, a, b));
      while (!seen && c < 100) begin
         @(negedge clk);
         if (bus.o_stall) stalls++;
         if (bus.o_valid) seen = 1;
         else begin
            @(posedge clk);
            #1;
            c++;
            // Late operand changes must not disturb the latched op
            bus.i_funct3 = 3'($urandom_range(0, 7));
            bus.i_op_a   = $urandom();
            bus.i_op_b   = $urandom();
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL timeout: no o_valid within 100 cycles for funct3=%0d", f);
         void'(exp_q.pop_back());
      end else begin
         check("latency", 32'(c), 32'(exp_lat));
         check("stall_cycles", 32'(stalls), 32'(exp_lat));
      end
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
   endtask

   logic [2:0]  dir_f[12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd5, 3'd6, 3'd4, 3'd6};
   logic [31:0] dir_a[12] = '{32'd7, ONES, ONES, ONES, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'd5, 32'd5, MIN_NEG, MIN_NEG};
   logic [31:0] dir_b[12] = '{32'hFFFF_FFFD, ONES, ONES, 32'd2, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'd0, ONES, ONES};

   initial begin
      int vcount;
      int n;
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_state", 32'(bus.dbg_state), 32'd0);
      check("reset_valid", 32'(bus.o_valid), 32'd0);
      check("reset_busy", 32'(bus.o_busy), 32'd0);
      check("reset_result", bus.o_result, 32'd0);
      check("reset_stall", 32'(bus.o_stall), 32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) run_op(dir_f[i], dir_a[i], dir_b[i]);

      // Flush at T+10: no result, result register untouched
      bus.i_valid  = 1'b1;
      bus.i_funct3 = 3'd0;
      bus.i_op_a   = 32'd123;
      bus.i_op_b   = 32'd456;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      bus.i_flush = 1'b1;
      @(negedge clk);
      check("flush_stall", 32'(bus.o_stall), 32'd0);
      @(posedge clk);
      #1;
      bus.i_flush = 1'b0;
      bus.i_valid = 1'b0;
      @(negedge clk);
      check("flush_busy", 32'(bus.o_busy), 32'd0);
      check("flush_result_held", bus.o_result, last_exp);
      vcount = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.o_valid) vcount++;
      end
      check("flush_no_valid", 32'(vcount), 32'd0);
      @(posedge clk);
      #1;
      run_op(3'd5, 32'd9, 32'd3);

      // Reset at T+5 of a running op
      bus.i_valid  = 1'b1;
      bus.i_funct3 = 3'd4;
      bus.i_op_a   = 32'd1000;
      bus.i_op_b   = 32'd7;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.i_valid = 1'b0;
      @(negedge clk);
      check("midrst_valid", 32'(bus.o_valid), 32'd0);
      check("midrst_busy", 32'(bus.o_busy), 32'd0);
      check("midrst_result", bus.o_result, 32'd0);
      check("midrst_state", 32'(bus.dbg_state), 32'd0);
      @(posedge clk);
      #1;

      // Back-to-back MUL then DIV
      n = pulse_q.size();
      run_op(3'd0, 32'd12345, 32'hFFFF_0001);
      run_op(3'd4, 32'hFFFF_1234, 32'd77);
      if (pulse_q.size() >= n + 2)
         check("b2b_gap", 32'(pulse_q[n+1] - pulse_q[n]), 32'd34);
      else
         check("b2b_pulses", 32'(pulse_q.size() - n), 32'd2);

      // Randomised ops, biased toward the divide corner cases
      for (int i = 0; i < 40; i++) begin
         logic [2:0]  f;
         logic [31:0] a, b;
         int          sel;
         f   = 3'($urandom_range(0, 7));
         sel = $urandom_range(0, 7);
         a   = $urandom();
         b   = $urandom();
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin a = MIN_NEG; b = ONES; end
         else if (sel == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
         else if (sel == 3) b = ONES - 32'($urandom_range(0, 3));
         run_op(f, a, b);
      end

      repeat (5) @(posedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
